// File: rtl/step_generator.sv
// Memory-mapped step/direction pulse generator for the picorv32 data bus.
// Optional POSITION counter at word 3 is built when STEP_POSITION_EN is defined.
module step_generator #(
  parameter int DATA_WIDTH  = 32,
  parameter int PULSE_WIDTH = 4,
  parameter int DIR_SETUP   = 8
) (
  input  logic                  clk_in,
  input  logic                  reset_in,
  input  logic                  enable_in,
  input  logic                  write_in,
  input  logic [1:0]            addr_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  ready_out,
  output logic                  step_out,
  output logic                  dir_out,
  output logic                  driver_en_n_out,
  output logic                  busy_out
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_HIGH, S_LOW} state_t;

  localparam logic [DATA_WIDTH-1:0] ONE        = DATA_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] PW_W       = DATA_WIDTH'(PULSE_WIDTH);
  localparam logic [DATA_WIDTH-1:0] MIN_PERIOD = DATA_WIDTH'(PULSE_WIDTH + 1);
  localparam logic [DATA_WIDTH-1:0] SETUP_LAST = DATA_WIDTH'(DIR_SETUP - 1);
  localparam logic [DATA_WIDTH-1:0] HIGH_LAST  = DATA_WIDTH'(PULSE_WIDTH - 1);

  state_t                r_state, w_state_nxt;
  logic [DATA_WIDTH-1:0] r_cnt, w_cnt_nxt;
  logic [DATA_WIDTH-1:0] r_period, r_remaining, r_low_last, r_data_out;
  logic                  r_en_d, r_ready, r_drv_en, r_dir, r_dir_out, r_done, r_abort_pend;

  logic                  w_access, w_wr, w_wr_ctrl, w_busy, w_start, w_abort_wr;
  logic                  w_enter_high, w_enter_low, w_finish;
  logic [DATA_WIDTH-1:0] w_eff_period, w_rdata, w_pos_rd;

  assign w_access     = enable_in & ~r_en_d;
  assign w_wr         = w_access & write_in;
  assign w_wr_ctrl    = w_wr && (addr_in == 2'd0);
  assign w_busy       = (r_state != S_IDLE);
  assign w_start      = w_wr_ctrl && !w_busy && data_in[2] && data_in[0] && (r_remaining != '0);
  // While running, clearing drv_en is treated exactly like an explicit abort.
  assign w_abort_wr   = w_wr_ctrl && w_busy && (data_in[3] || !data_in[0]);
  assign w_eff_period = (r_period < MIN_PERIOD) ? MIN_PERIOD : r_period;

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt + ONE;
    w_enter_high = 1'b0;
    w_enter_low  = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (w_start) w_state_nxt = S_SETUP;
      end
      S_SETUP: begin
        if (w_abort_wr) begin
          w_state_nxt = S_IDLE;
          w_finish    = 1'b1;
        end else if (r_cnt == SETUP_LAST) begin
          w_state_nxt  = S_HIGH;
          w_cnt_nxt    = '0;
          w_enter_high = 1'b1;
        end
      end
      S_HIGH: begin
        // The pulse always runs to completion; a pending abort is honoured at its end.
        if (r_cnt == HIGH_LAST) begin
          w_cnt_nxt = '0;
          if (r_abort_pend || w_abort_wr) begin
            w_state_nxt = S_IDLE;
            w_finish    = 1'b1;
          end else begin
            w_state_nxt = S_LOW;
            w_enter_low = 1'b1;
          end
        end
      end
      S_LOW: begin
        if (w_abort_wr) begin
          w_state_nxt = S_IDLE;
          w_finish    = 1'b1;
        end else if (r_cnt == r_low_last) begin
          w_cnt_nxt = '0;
          if (r_remaining != '0 && !r_abort_pend) begin
            w_state_nxt  = S_HIGH;
            w_enter_high = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
            w_finish    = 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

`ifdef STEP_POSITION_EN
  logic [DATA_WIDTH-1:0] r_pos;
  always_ff @(posedge clk_in) begin
    if (reset_in)
      r_pos <= '0;
    else if (w_wr && addr_in == 2'd3 && !w_busy)
      r_pos <= data_in;
    else if (w_enter_high)
      r_pos <= r_pos + (r_dir_out ? ONE : '1);
  end
  assign w_pos_rd = r_pos;
`else
  assign w_pos_rd = '0;
`endif

  always_comb begin
    w_rdata = '0;
    case (addr_in)
      2'd0: w_rdata = {{(DATA_WIDTH-6){1'b0}}, r_done, w_busy, 2'b00, r_dir, r_drv_en};
      2'd1: w_rdata = r_period;
      2'd2: w_rdata = r_remaining;
      2'd3: w_rdata = w_pos_rd;
      default: w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_period     <= '0;
      r_remaining  <= '0;
      r_low_last   <= '0;
      r_data_out   <= '0;
      r_en_d       <= 1'b0;
      r_ready      <= 1'b0;
      r_drv_en     <= 1'b0;
      r_dir        <= 1'b0;
      r_dir_out    <= 1'b0;
      r_done       <= 1'b0;
      r_abort_pend <= 1'b0;
    end else begin
      r_en_d     <= enable_in;
      r_ready    <= w_access;
      r_data_out <= (w_access && !write_in) ? w_rdata : '0;
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;

      if (w_wr_ctrl) begin
        r_drv_en <= data_in[0];
        if (!w_busy) r_dir <= data_in[1];
      end
      if (w_wr && addr_in == 2'd1) r_period <= data_in;

      if (w_wr && addr_in == 2'd2 && !w_busy)
        r_remaining <= data_in;
      else if (w_enter_high && r_remaining != '0)
        r_remaining <= r_remaining - ONE;

      // Period is sampled at each LOW entry so mid-run PERIOD writes apply cleanly.
      if (w_enter_low) r_low_last <= w_eff_period - PW_W - ONE;

      if (w_start) begin
        r_dir_out <= data_in[1];
        r_done    <= 1'b0;
      end else if (w_finish) begin
        r_done <= 1'b1;
      end

      if (w_state_nxt == S_IDLE)
        r_abort_pend <= 1'b0;
      else if (r_state == S_HIGH && w_abort_wr)
        r_abort_pend <= 1'b1;
    end
  end

  assign data_out        = r_data_out;
  assign ready_out       = r_ready;
  assign step_out        = (r_state == S_HIGH);
  assign dir_out         = r_dir_out;
  assign driver_en_n_out = ~r_drv_en;
  assign busy_out        = w_busy;

endmodule
